// File: rtl/reg2apb_native_if.sv
// reg2apb_native_if: native req/ack to APB master bridge; define REG2APB_TIMEOUT_EN to bound ACCESS wait states
module reg2apb_native_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_vld,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  ack_vld,
  output logic                  ack_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;
  state_t state, next_state;
  logic accept, done, timeout;
  assign accept = state == S_IDLE && req_vld && (wr_en || rd_en);
`ifdef REG2APB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] wait_cnt;
  assign timeout = state == S_ACCESS && !pready && wait_cnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst || accept)
      wait_cnt <= '0;
    else if (state == S_ACCESS && !pready)
      wait_cnt <= wait_cnt + 1'b1;
  end
`else
  assign timeout = 1'b0;
`endif
  assign done = state == S_ACCESS && (pready || timeout);
  assign psel = state != S_IDLE;
  assign penable = state == S_ACCESS;
  always_comb begin
    next_state = accept ? S_SETUP : state == S_SETUP ? S_ACCESS : done ? S_IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
      rd_data <= '0;
      ack_vld <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      state   <= next_state;
      ack_vld <= done;
      ack_err <= done && (timeout || pslverr);
      if (accept) begin
        pwrite <= wr_en;
        paddr  <= addr;
        pwdata <= wr_data;
      end
      if (done && !pwrite)
        rd_data <= timeout ? '0 : prdata;
    end
  end
endmodule

// File: tb/tb_reg2apb_native_if.sv
// tb_reg2apb_native_if: directed vector table, hand sequences and randomized transactions vs a transaction model
module tb_reg2apb_native_if;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [63:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic        ack_vld, ack_err;
  logic [31:0] rd_data;
  logic        psel, penable, pwrite;
  logic [63:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic [31:0] prdata = '0;
  logic        pslverr = 1'b0;
  int tests = 0, fails = 0;
  logic [31:0] last_rd = '0;
  reg2apb_native_if #(.ADDR_WIDTH(64), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
    .wr_data(wr_data), .ack_vld(ack_vld), .ack_err(ack_err), .rd_data(rd_data), .psel(psel),
    .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pready(pready),
    .prdata(prdata), .pslverr(pslverr)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        w, r;
    logic [63:0] a;
    logic [31:0] d;
    int          waits;
    logic [31:0] prd;
    logic        err;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;
  vec_t vecs[5];
  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction
  task automatic idle(input int n, input logic noisy);
    for (int i = 0; i < n; i++) begin
      req_vld = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(negedge clk);
      chk("idle_psel", psel, 0);
      chk("idle_ack", ack_vld, 0);
    end
    req_vld = 1'b0;
  endtask
  task automatic xfer(input logic w, input logic r, input logic [63:0] a, input logic [31:0] d,
                      input int waits, input logic [31:0] prd, input logic err, input logic intr,
                      input logic exp_err, input logic [31:0] exp_rd);
    int en_cnt = 0;
    req_vld = 1'b1; wr_en = w; rd_en = r; addr = a; wr_data = d;
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    addr = {$urandom, $urandom}; wr_data = $urandom;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, a);
    chk("setup_pwdata", pwdata, d);
    chk("setup_pwrite", pwrite, w);
    chk("ack_single", ack_vld, 0);
    chk("rd_hold", rd_data, last_rd);
    for (int k = 0; k <= waits; k++) begin
      @(negedge clk);
      if (psel && penable) en_cnt++;
      chk("acc_paddr", paddr, a);
      chk("acc_pwrite", pwrite, w);
      chk("acc_pwdata", pwdata, d);
      chk("acc_noack", ack_vld, 0);
      pready = k == waits;
      prdata = k == waits ? prd : $urandom;
      pslverr = k == waits ? err : 1'($urandom_range(0, 1));
      req_vld = intr && k == 0;
      wr_en = intr && k == 0;
    end
    @(negedge clk);
    req_vld = 1'b0; wr_en = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    chk("penable_cycles", 64'(en_cnt), 64'(waits + 1));
    chk("ack_vld", ack_vld, 1);
    chk("ack_err", ack_err, exp_err);
    chk("ack_rd_data", rd_data, exp_rd);
    chk("ack_psel", psel, 0);
    chk("ack_penable", penable, 0);
    last_rd = exp_rd;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    logic [31:0] model_rd;
    vecs[0] = '{1'b1, 1'b0, 64'h10, 32'hDEADBEEF, 0, 32'h55, 1'b0, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 64'h20, 32'h0, 3, 32'h12345678, 1'b0, 1'b0, 32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 64'h30, 32'h9, 1, 32'hBAD, 1'b1, 1'b1, 32'hBAD};
    vecs[3] = '{1'b1, 1'b1, 64'h40, 32'hCAFEF00D, 2, 32'h77, 1'b0, 1'b0, 32'hBAD};
    vecs[4] = '{1'b1, 1'b0, 64'h50, 32'h1, 0, 32'h66, 1'b1, 1'b1, 32'hBAD};
    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_ack_vld", ack_vld, 0);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    idle(2, 1'b0);
    foreach (vecs[i])
      xfer(vecs[i].w, vecs[i].r, vecs[i].a, vecs[i].d, vecs[i].waits, vecs[i].prd,
           vecs[i].err, 1'b0, vecs[i].exp_err, vecs[i].exp_rd);
    idle(4, 1'b1);
    xfer(1'b0, 1'b1, 64'h60, 32'h3, 2, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
    idle(3, 1'b0);
    req_vld = 1'b1; rd_en = 1'b1; addr = 64'h70;
    @(negedge clk);
    req_vld = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    chk("pre_rst_access", penable, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_psel", psel, 0);
    chk("abort_penable", penable, 0);
    chk("abort_paddr", paddr, 0);
    chk("abort_pwdata", pwdata, 0);
    chk("abort_pwrite", pwrite, 0);
    chk("abort_rd_data", rd_data, 0);
    chk("abort_ack", ack_vld, 0);
    last_rd = '0;
    idle(3, 1'b0);
    xfer(1'b0, 1'b1, 64'h80, 32'h0, 1, 32'h0F0F1234, 1'b0, 1'b0, 1'b0, 32'h0F0F1234);
`ifdef REG2APB_TIMEOUT_EN
    req_vld = 1'b1; rd_en = 1'b1; addr = 64'h90;
    @(negedge clk);
    req_vld = 1'b0; rd_en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("to_psel", psel, 1);
      chk("to_penable", penable, 1);
    end
    @(negedge clk);
    chk("to_psel_drop", psel, 0);
    chk("to_ack_vld", ack_vld, 1);
    chk("to_ack_err", ack_err, 1);
    chk("to_rd_data", rd_data, 0);
    last_rd = '0;
`else
    xfer(1'b0, 1'b1, 64'h90, 32'h0, 20, 32'h13579BDF, 1'b0, 1'b0, 1'b0, 32'h13579BDF);
`endif
    model_rd = last_rd;
    for (int n = 0; n < 40; n++) begin
      logic [1:0] q;
      logic [31:0] prd;
      logic err;
      q = 2'($urandom_range(1, 3));
      prd = $urandom;
      err = 1'($urandom_range(0, 3) == 0);
      if (q == 2'b01) model_rd = prd;
      xfer(q[1], q[0], {$urandom, $urandom}, $urandom, int'($urandom_range(0, 5)), prd, err,
           1'($urandom_range(0, 1)), err, model_rd);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)), 1'b1);
    end
    idle(2, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/reg2apb_native_if.md
# reg2apb_native_if

Bridge from the register native request interface (req_vld / ack_vld) to an APB master port. It sits between a native-interface initiator, such as a register-access engine or a debug port, and an APB bus, so that native requests can reach APB-attached register blocks. Each native request becomes exactly one APB SETUP + ACCESS transfer. The APB response is returned as a single-cycle registered ack_vld pulse, with rd_data held until the next ack.

## Interface
- ADDR_WIDTH, 64, address width on both sides
- DATA_WIDTH, 32, data width on both sides
- TIMEOUT_CYCLES, 256, maximum ACCESS cycles spent waiting for pready (used only with REG2APB_TIMEOUT_EN); legal range ≥ 2
- clk  input  1  single clock for all logic
- rst  input  1  synchronous, active-high reset
- req_vld  input  1  single-cycle native request strobe
- wr_en  input  1  write qualifier, sampled with req_vld
- rd_en  input  1  read qualifier, sampled with req_vld
- addr  input  ADDR_WIDTH  request address, sampled with req_vld
- wr_data  input  DATA_WIDTH  write data, sampled with req_vld
- ack_vld  output  1  single-cycle completion pulse
- ack_err  output  1  error flag, valid only while ack_vld=1
- rd_data  output  DATA_WIDTH  read data; updated on read acks, held otherwise
- psel  output  1  APB select
- penable  output  1  APB enable
- pwrite  output  1  APB direction
- paddr  output  ADDR_WIDTH  APB address
- pwdata  output  DATA_WIDTH  APB write data
- pready  input  1  APB ready
- prdata  input  DATA_WIDTH  APB read data
- pslverr  input  1  APB slave error

## Operation
- FSM states: S_IDLE, S_SETUP, S_ACCESS.
- Request acceptance:
  - A request is accepted only in S_IDLE when req_vld & (wr_en | rd_en).
  - If wr_en and rd_en are both set, the request is a write.
  - req_vld with neither qualifier is ignored.
  - req_vld outside S_IDLE is an initiator protocol violation and is ignored: no capture, no ack.
- On acceptance:
  - addr, wr_data and direction are captured into paddr, pwdata and pwrite.
  - Next state is S_SETUP.
- S_SETUP: psel=1, penable=0; unconditionally go to S_ACCESS.
- S_ACCESS: psel=1, penable=1.
  - pready=1: go to S_IDLE; next cycle ack_vld=1 and ack_err=pslverr.
  - Read with pready=1: rd_data <= prdata on the same edge, even if pslverr=1.
  - pready=0: remain in S_ACCESS.
- paddr, pwdata and pwrite are held stable from S_SETUP through the last S_ACCESS cycle. They keep their last values in S_IDLE.
- Write acks leave rd_data unchanged.
- ack_vld is a register and is high for exactly one cycle per accepted request.
- Reset:
  - psel, penable, pwrite, ack_vld and ack_err reset to 0.
  - paddr, pwdata and rd_data reset to all zeros.
  - State resets to S_IDLE.
  - rst asserted mid-transfer aborts the transfer at that edge with no ack; psel and penable are 0 the following cycle.

## Timing
- Request sampled at edge N → S_SETUP in cycle N+1 → S_ACCESS in cycle N+2.
- With pready=1 in the first ACCESS cycle, ack_vld is high in cycle N+3. Minimum request-to-ack latency is 3 cycles.
- Each wait-state cycle (pready=0) adds one cycle of latency.
- The earliest next request is accepted in the cycle ack_vld is high, since the FSM is already in S_IDLE. Back-to-back transfers have one idle bus cycle between them.
- No combinational path exists from any input to any output.

## Configuration
- Macro: REG2APB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES) counts S_ACCESS cycles with pready=0.
  - If the TIMEOUT_CYCLES-th consecutive ACCESS cycle still has pready=0, the FSM goes to S_IDLE and drops psel and penable.
  - Next cycle: ack_vld=1, ack_err=1, rd_data=0 for reads, unchanged for writes.
  - The counter clears on entry to S_SETUP.
- Undefined: no counter is instantiated, S_ACCESS waits indefinitely, and TIMEOUT_CYCLES is unused.

## Test plan
- Write 0x0000_0000_0000_0010 ← 0xDEADBEEF, pready=1 at once: SETUP at N+1, ACCESS at N+2 with pwrite=1 and the expected paddr/pwdata; ack_vld=1, ack_err=0 at N+3; rd_data unchanged.
- Read 0x20, slave returns prdata=0x12345678 after 3 wait states: penable high for 4 cycles; ack at N+6; rd_data=0x12345678, held after ack.
- Read with pslverr=1, prdata=0xBAD: ack_err=1 with ack_vld; rd_data=0xBAD.
- req_vld pulsed during S_ACCESS, plus req_vld with wr_en=rd_en=0 in S_IDLE: neither produces an APB transfer or an ack. Request with wr_en=rd_en=1 performs a write.
- rst asserted in S_ACCESS, then released: psel=0, penable=0, all outputs zero, no ack_vld. A new read then completes normally.
- With REG2APB_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0: penable high for 4 ACCESS cycles, then psel=0; ack_vld=1, ack_err=1, rd_data=0 on the following cycle.
